// File: rtl/mips_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips_ctrl_pkg
// Brief    : Shared opcodes, datapath select encodings, FSM states and the
//            per-state control decode for the multicycle MIPS control unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] ALU_R      = 6'h00;
  localparam logic [5:0] ADDI       = 6'h08;
  localparam logic [5:0] BRANCH_EQ  = 6'h04;
  localparam logic [5:0] BRANCH_NE  = 6'h05;
  localparam logic [5:0] JUMP       = 6'h02;
  localparam logic [5:0] LOAD_WORD  = 6'h23;
  localparam logic [5:0] STORE_WORD = 6'h2B;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_SUB    = 2'd1;
  localparam logic [1:0] ALUOP_R_TYPE = 2'd2;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_FAULT    = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Moore control word for a state; FETCH's mem_ready-qualified strobes are added in the top.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PC_SRC_ALU;
      end
      S_DECODE:   c.alu_src_b = SRC_B_IMM_SH2;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write = 1'b1;
        c.mem_2_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_REG;
        c.alu_op    = ALUOP_R_TYPE;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
      end
      S_ADDI_WB:  c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRC_B_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_SRC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control_unit
// Brief    : Moore FSM sequencing the multicycle MIPS datapath, with memory
//            ready timeout, illegal-opcode and fault flags.
//            Optional feature macro: CTRL_BNE_EN (adds BNE, opcode 0x05).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_2_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       fault
);

  localparam int               TMO_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] C_TMO_MAX  = TMO_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_next;
  state_t           w_decode_next;
  ctrl_t            r_ctrl;
  logic [TMO_W-1:0] r_wait_cnt;
  logic             r_is_store;
  logic             r_illegal_op;
  logic             r_fault;
  logic             r_branch_ne;
  logic             w_waiting;
  logic             w_timeout;
  logic             w_op_illegal;
  logic             w_op_bne;
  logic             w_fetch_done;

  always_comb begin
    w_decode_next = S_FETCH;
    w_op_illegal  = 1'b0;
    w_op_bne      = 1'b0;
    case (opcode)
      ALU_R:                 w_decode_next = S_EXEC;
      ADDI:                  w_decode_next = S_ADDI_EX;
      LOAD_WORD, STORE_WORD: w_decode_next = S_MEM_ADDR;
      BRANCH_EQ:             w_decode_next = S_BRANCH;
      JUMP:                  w_decode_next = S_JUMP;
`ifdef CTRL_BNE_EN
      BRANCH_NE: begin
        w_decode_next = S_BRANCH;
        w_op_bne      = 1'b1;
      end
`else
      BRANCH_NE:             w_op_illegal = 1'b1;
`endif
      default:               w_op_illegal = 1'b1;
    endcase

    w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // Ready in the cycle the count would reach the limit still advances normally.
    w_timeout = w_waiting && !mem_ready && (r_wait_cnt >= C_TMO_LAST);

    w_next = r_state;
    case (r_state)
      S_RESET:    w_next = S_FETCH;
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE:   w_next = w_decode_next;
      S_MEM_ADDR: w_next = r_is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_EXEC:     w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_ADDI_EX:  w_next = S_ADDI_WB;
      S_ADDI_WB:  w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_FAULT:    w_next = S_FAULT;
      default:    w_next = S_FAULT;
    endcase
    if (w_timeout) w_next = S_FAULT;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state      <= S_RESET;
      r_is_store   <= 1'b0;
      r_illegal_op <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_is_store <= (opcode == STORE_WORD);
        if (w_op_illegal) r_illegal_op <= 1'b1;
      end
      if (w_next == S_FAULT) r_fault <= 1'b1;
    end
  end

  // Saturating wait counter; held in FAULT, cleared whenever a wait ends.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wait_cnt <= '0;
    end else if (w_waiting && !mem_ready) begin
      if (r_wait_cnt != C_TMO_MAX) r_wait_cnt <= r_wait_cnt + TMO_W'(1);
    end else if (r_state != S_FAULT) begin
      r_wait_cnt <= '0;
    end
  end

  // Outputs registered from the next state so they change cleanly with the state.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ctrl      <= '0;
      r_branch_ne <= 1'b0;
    end else begin
      r_ctrl      <= state_ctrl(w_next);
      r_branch_ne <= (r_state == S_DECODE) && (w_next == S_BRANCH) && w_op_bne;
    end
  end

  assign w_fetch_done  = (r_state == S_FETCH) && mem_ready;

  assign pc_write      = r_ctrl.pc_write | w_fetch_done;
  assign ir_write      = w_fetch_done;
  assign pc_write_cond = r_ctrl.pc_write_cond;
  assign branch_ne     = r_branch_ne;
  assign iord          = r_ctrl.iord;
  assign mem_read      = r_ctrl.mem_read;
  assign mem_write     = r_ctrl.mem_write;
  assign mem_2_reg     = r_ctrl.mem_2_reg;
  assign reg_dst       = r_ctrl.reg_dst;
  assign reg_write     = r_ctrl.reg_write;
  assign alu_src_a     = r_ctrl.alu_src_a;
  assign alu_src_b     = r_ctrl.alu_src_b;
  assign alu_op        = r_ctrl.alu_op;
  assign pc_source     = r_ctrl.pc_source;
  assign illegal_op    = r_illegal_op;
  assign fault         = r_fault;

endmodule

`default_nettype wire
